// File: rtl/im_load_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-memory load/fetch controller.
package im_load_fetch_ctrl_pkg;

    localparam int unsigned IM_DEPTH = 16;
    localparam int unsigned IM_AW    = 4;
    localparam int unsigned IM_DW    = 32;

    // Instruction returned for a rejected fetch.
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/im_load_fetch_ctrl_if.sv
// Program-loader word stream: the loader is the master, the controller the slave.
interface im_load_fetch_ctrl_if #(
    parameter int unsigned DW = 32
) ();

    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;

    modport master (
        output ld_start,
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_start,
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );

endinterface

// File: rtl/im_load_fetch_ctrl_addr_check.sv
// Flags fetch addresses that are not word aligned or fall beyond the IM.
module im_load_fetch_ctrl_addr_check #(
    parameter int unsigned AW = 4
) (
    input  logic [31:0] pc,
    output logic        err
);

    // Misaligned if the byte offset is nonzero; out of range if any bit above the word index is set.
    always_comb begin
        err = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
    end

endmodule

// File: rtl/im_load_fetch_ctrl.sv
// Owns the IM address/write port: sequences program loads, stalls fetch during them,
// and registers fetched instructions with a one-cycle latency.
module im_load_fetch_ctrl
    import im_load_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = IM_DEPTH,
    parameter int unsigned AW    = IM_AW,
    parameter int unsigned DW    = IM_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [31:0]          fetch_pc,
    im_load_fetch_ctrl_if.slave  ld,
    input  logic [DW-1:0]        im_ir,
    output logic [31:0]          im_pc,
    output logic [DW-1:0]        im_data,
    output logic                 im_write,
    output logic                 im_read,
    output logic                 stall,
    output logic                 fetch_valid,
    output logic [DW-1:0]        fetch_instr,
    output logic                 fetch_err,
    output logic                 load_done,
    output logic                 load_err,
    output logic [AW:0]          load_count
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    state_t state;
    logic   addr_err;
    logic   ready;
    logic   word_acc;

    im_load_fetch_ctrl_addr_check #(
        .AW (AW)
    ) u_addr_check (
        .pc  (fetch_pc),
        .err (addr_err)
    );

    assign word_acc    = ld.ld_valid & ready;
    assign ld.ld_ready = ready;

    // FSM, load counter and registered fetch/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            load_count  <= '0;
            load_err    <= 1'b0;
            load_done   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_instr <= DW'(NOP);
        end else begin
            load_done   <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            unique case (state)
                StIdle: begin
                    // A load start takes priority over a fetch in the same cycle.
                    if (ld.ld_start) begin
                        state      <= StLoad;
                        load_count <= '0;
                        load_err   <= 1'b0;
                    end else if (fetch_req) begin
                        fetch_valid <= 1'b1;
                        fetch_err   <= addr_err;
                        fetch_instr <= addr_err ? DW'(NOP) : im_ir;
                    end
                end
                StLoad: begin
                    if (word_acc) begin
                        load_count <= load_count + 1'b1;
                        if (ld.ld_last) begin
                            state     <= StDone;
                            load_done <= 1'b1;
                        end
                    end else if (load_count == DEPTH_CNT) begin
                        // IM is full and no last word seen: abandon the stream.
                        load_err  <= 1'b1;
                        state     <= StDone;
                        load_done <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // IM port muxing: fetch owns the port in idle, the loader owns it otherwise.
    always_comb begin
        ready    = 1'b0;
        im_pc    = fetch_pc;
        im_data  = '0;
        im_write = 1'b0;
        im_read  = 1'b0;
        stall    = 1'b0;
        unique case (state)
            StIdle: begin
                im_read = fetch_req;
                stall   = ld.ld_start;
            end
            StLoad: begin
                stall    = 1'b1;
                ready    = (load_count < DEPTH_CNT);
                im_pc    = 32'({load_count, 2'b00});
                im_data  = ld.ld_data;
                im_write = ld.ld_valid & ready;
            end
            StDone: begin
                stall = 1'b1;
                im_pc = 32'({load_count, 2'b00});
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_im_load_fetch_ctrl.sv
// Directed bench for im_load_fetch_ctrl with an IM_Mem model and a fetch scoreboard.
module tb_im_load_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic [31:0] im_ir;
    logic [31:0] im_pc;
    logic [31:0] im_data;
    logic        im_write;
    logic        im_read;
    logic        stall;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        load_done;
    logic        load_err;
    logic [4:0]  load_count;

    int checks = 0;
    int errors = 0;
    int exp_idx = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] im_mem  [16];

    im_load_fetch_ctrl_if #(.DW(32)) ld_if ();

    im_load_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .ld          (ld_if),
        .im_ir       (im_ir),
        .im_pc       (im_pc),
        .im_data     (im_data),
        .im_write    (im_write),
        .im_read     (im_read),
        .stall       (stall),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_err   (fetch_err),
        .load_done   (load_done),
        .load_err    (load_err),
        .load_count  (load_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // IM_Mem model: reset reloads the init image, writes land on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) im_mem[i] <= init_word(i);
        end else if (im_write) begin
            im_mem[im_pc[5:2]] <= im_data;
        end
    end

    assign im_ir = im_mem[im_pc[5:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every fetch_valid pulse must match the oldest outstanding fetch.
    always @(negedge clk) begin
        if (!reset && fetch_valid) begin
            exp_t e;
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_fetch_valid: observed 1 expected 0");
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("fetch_instr", fetch_instr, e.instr);
                chk("fetch_err", 32'(fetch_err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        exp_t e;
        logic bad;
        bad = (pc[1:0] != 2'b00) || (pc[31:6] != 26'd0);
        e.err   = bad;
        e.instr = bad ? 32'h0 : ref_mem[pc[5:2]];
        q.push_back(e);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        #1;
        chk("im_read", 32'(im_read), 32'd1);
        tick();
        fetch_req = 1'b0;
        fetch_pc  = 32'h0;
    endtask

    task automatic start_load(input logic with_fetch);
        ld_if.ld_start = 1'b1;
        fetch_req      = with_fetch;
        fetch_pc       = 32'h4;
        #1;
        chk("stall_on_start", 32'(stall), 32'd1);
        tick();
        ld_if.ld_start = 1'b0;
        fetch_req      = 1'b0;
        fetch_pc       = 32'h0;
        exp_idx        = 0;
        chk("start_no_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("start_load_err", 32'(load_err), 32'd0);
        chk("start_load_count", 32'(load_count), 32'd0);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic exp_ready);
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = d;
        ld_if.ld_last  = last;
        #1;
        chk("ld_ready", 32'(ld_if.ld_ready), 32'(exp_ready));
        chk("im_write", 32'(im_write), 32'(exp_ready));
        chk("stall_load", 32'(stall), 32'd1);
        if (exp_ready) begin
            chk("im_pc_load", im_pc, 32'(exp_idx * 4));
            chk("im_data_load", im_data, d);
        end
        tick();
        if (exp_ready) begin
            ref_mem[exp_idx] = d;
            exp_idx++;
        end
        ld_if.ld_valid = 1'b0;
        ld_if.ld_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: observed timeout expected finish");
    end

    initial begin
        reset          = 1'b1;
        fetch_req      = 1'b0;
        fetch_pc       = 32'h0;
        ld_if.ld_start = 1'b0;
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = 32'h0;
        ld_if.ld_last  = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        repeat (3) tick();

        // Reset state.
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ld_ready", 32'(ld_if.ld_ready), 32'd0);
        chk("rst_im_write", 32'(im_write), 32'd0);
        chk("rst_im_read", 32'(im_read), 32'd0);
        chk("rst_im_pc", im_pc, 32'd0);
        chk("rst_im_data", im_data, 32'd0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_fetch_instr", fetch_instr, 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        reset = 1'b0;
        tick();

        // Fetch from the init image.
        do_fetch(32'h0);
        do_fetch(32'h4);
        tick();

        // Three-word load, last on the third.
        start_load(1'b0);
        send_word(32'hAAAA_0001, 1'b0, 1'b1);
        send_word(32'hBBBB_0002, 1'b0, 1'b1);
        send_word(32'hCCCC_0003, 1'b1, 1'b1);
        chk("abc_load_done", 32'(load_done), 32'd1);
        chk("abc_load_count", 32'(load_count), 32'd3);
        chk("abc_done_stall", 32'(stall), 32'd1);
        chk("abc_done_ready", 32'(ld_if.ld_ready), 32'd0);
        tick();
        chk("abc_done_pulse", 32'(load_done), 32'd0);
        chk("abc_idle_stall", 32'(stall), 32'd0);
        do_fetch(32'h8);
        do_fetch(32'h0);
        do_fetch(32'hC);

        // Load start colliding with a fetch; fetches during the load are ignored.
        start_load(1'b1);
        fetch_req = 1'b1;
        fetch_pc  = 32'h4;
        send_word(32'hDDDD_0004, 1'b0, 1'b1);
        fetch_req = 1'b1;
        send_word(32'hEEEE_0005, 1'b1, 1'b1);
        fetch_req = 1'b1;
        chk("de_load_done", 32'(load_done), 32'd1);
        chk("de_load_count", 32'(load_count), 32'd2);
        tick();
        fetch_req = 1'b0;
        do_fetch(32'h4);
        do_fetch(32'h8);

        // Overflow: 17 words, no last.
        start_load(1'b0);
        for (int i = 0; i < 16; i++) send_word(32'hF000_0000 + 32'(i), 1'b0, 1'b1);
        chk("ovf_count_full", 32'(load_count), 32'd16);
        send_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("ovf_load_err", 32'(load_err), 32'd1);
        chk("ovf_load_done", 32'(load_done), 32'd1);
        chk("ovf_load_count", 32'(load_count), 32'd16);
        tick();
        chk("ovf_err_sticky", 32'(load_err), 32'd1);
        chk("ovf_idle_stall", 32'(stall), 32'd0);
        do_fetch(32'h3C);
        do_fetch(32'h0);

        // Misaligned and out-of-range fetches.
        do_fetch(32'h6);
        do_fetch(32'h40);
        do_fetch(32'h8000_0000);
        do_fetch(32'h20);

        // Reset in the middle of a load discards it and restores the init image.
        start_load(1'b0);
        send_word(32'h1111_0001, 1'b0, 1'b1);
        send_word(32'h2222_0002, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_ready", 32'(ld_if.ld_ready), 32'd0);
        chk("mid_rst_count", 32'(load_count), 32'd0);
        do_fetch(32'h4);
        do_fetch(32'h0);

        repeat (2) tick();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
